// File: rtl/core_pkg.sv
// Shared widths and the write-back request type for the register-file write side.
package core_pkg;
  localparam int XLEN  = 32;
  localparam int RA_W  = 6;
  localparam int NREGS = 32;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // x0 and indices beyond the architectural file never write and never track.
  function automatic logic rd_legal(input logic [RA_W-1:0] rd);
    return (rd != '0) && (32'(rd) < NREGS);
  endfunction
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register plus hazard lookups.
module wb_scoreboard
  import core_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             set_en,
  input  logic [RA_W-1:0]  set_idx,
  input  logic             clr_en,
  input  logic [RA_W-1:0]  clr_idx,
  input  logic [RA_W-1:0]  rs1,
  input  logic [RA_W-1:0]  rs2,
  input  logic [RA_W-1:0]  rd,
  output logic [NREGS-1:0] busy_o,
  output logic             hz_rs1,
  output logic             hz_rs2,
  output logic             hz_rd
);
  localparam int IDX_W = $clog2(NREGS);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  function automatic logic lookup(input logic [NREGS-1:0] v, input logic [RA_W-1:0] idx);
    return rd_legal(idx) && v[idx[IDX_W-1:0]];
  endfunction

  // Clear is applied before set so that a coincident set of the same bit wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (clr_en && rd_legal(clr_idx)) busy_d[clr_idx[IDX_W-1:0]] = 1'b0;
      if (set_en && rd_legal(set_idx)) busy_d[set_idx[IDX_W-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;
  assign hz_rs1 = lookup(busy_q, rs1);
  assign hz_rs2 = lookup(busy_q, rs2);
  assign hz_rd  = lookup(busy_q, rd);
endmodule

// File: rtl/rf_writeback.sv
// Register-file write-side controller: MEM>ALU result arbiter, registered write port,
// and issue gating against the pending-write scoreboard.
module rf_writeback
  import core_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             iss_valid,
  input  logic [RA_W-1:0]  iss_rd,
  input  logic [RA_W-1:0]  iss_rs1,
  input  logic [RA_W-1:0]  iss_rs2,
  output logic             iss_ready,
  input  logic             alu_valid,
  input  logic [RA_W-1:0]  alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic [XLEN-1:0]  mem_data,
  output logic             mem_ready,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [NREGS-1:0] busy_o
);
  logic            mem_acc;
  logic            alu_acc;
  wb_req_t         req;
  logic            we_d;
  logic            we_q;
  logic [RA_W-1:0] waddr_d;
  logic [RA_W-1:0] waddr_q;
  logic [XLEN-1:0] wdata_d;
  logic [XLEN-1:0] wdata_q;
  logic            hz_rs1;
  logic            hz_rs2;
  logic            hz_rd;
  logic            iss_fire;

  // Readies are forced low while reset is held.
  assign mem_ready = rst_n && !flush;
  assign alu_ready = rst_n && !flush && !mem_valid;
  assign iss_ready = rst_n && !flush && !hz_rs1 && !hz_rs2 && !hz_rd;

  assign mem_acc  = mem_valid && mem_ready;
  assign alu_acc  = alu_valid && alu_ready;
  assign iss_fire = iss_valid && iss_ready;

  always_comb begin
    req     = mem_acc ? '{rd: mem_rd, data: mem_data} : '{rd: alu_rd, data: alu_data};
    we_d    = (mem_acc || alu_acc) && rd_legal(req.rd);
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (we_d) begin
      waddr_d = req.rd;
      wdata_d = req.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

  // Busy bits clear on the edge that ends the rf_we cycle, not at accept.
  wb_scoreboard u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .set_en  (iss_fire),
    .set_idx (iss_rd),
    .clr_en  (we_q),
    .clr_idx (waddr_q),
    .rs1     (iss_rs1),
    .rs2     (iss_rs2),
    .rd      (iss_rd),
    .busy_o  (busy_o),
    .hz_rs1  (hz_rs1),
    .hz_rs2  (hz_rs2),
    .hz_rd   (hz_rd)
  );
endmodule
